mw_add_seq: RTL and testbench
=============================

Name: mw_add_seq

Overview:
- Multi-precision add/subtract sequencer that sits around the team's 16-bit combinational adder.
- Upstream role: slices wide operands into 16-bit words and drives the adder's a/b/cin, least-significant word first.
- Downstream role: captures the adder's sum/cout each cycle and chains the carry through a register.
- Assembles a WORDS*16-bit result and returns it on a valid/ready handshake.

Parameters:
W, 16, adder word width; must match the attached adder.
WORDS, 4, number of words per operand; legal range is WORDS >= 1.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operand request valid.
in_ready  out  1  block can accept an operand request.
op_a  in  W*WORDS  operand A.
op_b  in  W*WORDS  operand B.
op_cin  in  1  carry-in; used for add only.
op_sub  in  1  1 = compute A-B, 0 = compute A+B+op_cin.
add_a  out  W  word driven to adder input a.
add_b  out  W  word driven to adder input b; already inverted for subtract.
add_cin  out  1  carry driven to adder cin.
add_sum  in  W  adder sum; combinational response to add_a/add_b/add_cin.
add_cout  in  1  adder carry-out.
out_valid  out  1  result available.
out_ready  in  1  consumer accepts result.
result  out  W*WORDS  wide sum or difference.
cout  out  1  final carry; in subtract mode 1 means no borrow (A >= B unsigned).
overflow  out  1  signed two's-complement overflow of the full-width operation.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - result, cout, overflow = 0; add_a, add_b, add_cin = 0; word index and carry register = 0.
- States are IDLE, RUN, DONE.
- in_ready = (state == IDLE), decoded combinationally from state. No request is accepted in RUN or DONE.
- IDLE, on in_valid & in_ready at edge k:
  - Latch op_a, op_b, op_sub.
  - carry_reg = op_sub ? 1 : op_cin.
  - idx = 0; go to RUN.
- RUN, combinational drive:
  - add_a = A word[idx].
  - add_b = B word[idx] XOR {W{sub}}.
  - add_cin = carry_reg.
- RUN, at each edge:
  - result word[idx] <= add_sum; carry_reg <= add_cout; idx <= idx+1.
  - When idx == WORDS-1: cout <= add_cout; overflow <= (add_a[W-1] == add_b[W-1]) & (add_sum[W-1] != add_a[W-1]); go to DONE.
- Outside RUN, add_a, add_b and add_cin are held at 0.
- Latency: out_valid rises after edge k+WORDS, i.e. exactly WORDS cycles in RUN. WORDS = 1 gives a single RUN cycle.
- DONE:
  - out_valid = 1.
  - result, cout and overflow are held stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE; out_valid drops next cycle.
  - result, cout and overflow keep their last values in IDLE.
- Throughput: one operation per WORDS+2 cycles (accept, WORDS RUN, DONE handshake). No overlap of operations.
- op_a, op_b, op_cin and op_sub may change freely after acceptance; only the latched copies are used.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. Partial result is discarded and all outputs take their reset values.
- Result words are updated in place during RUN. result is only meaningful while out_valid = 1.
- Arithmetic is modulo 2^(W*WORDS). cout and overflow are computed exactly as a single wide adder would produce them.
- Bench wiring: no combinational path from add_sum/add_cout to any output other than via registers. in_ready and out_valid depend only on state.

Test Plan:
- WORDS=4, add: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 -> result 0x0, cout 1, overflow 0; out_valid high exactly 4 cycles after the accept edge. Adder inputs observed per RUN cycle: add_cin sequence 0,1,1,1.
- Subtract: A=0x0, B=0x1, op_sub=1 -> result 0xFFFF_FFFF_FFFF_FFFF, cout 0 (borrow), overflow 0. Second case: A=0x5, B=0x3 -> result 0x2, cout 1.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF + B=0x1 -> result 0x8000_0000_0000_0000, overflow 1, cout 0. Also 0x8000_0000_0000_0000 - 0x1 -> overflow 1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result/cout/overflow stable, in_ready 0, in_valid ignored. Raise out_ready -> out_valid 0 and in_ready 1 on next cycle. A back-to-back request is then accepted and completes correctly (A=0x1234, B=0x1 -> 0x1235).
- Reset mid-operation: assert rst after 2 RUN cycles -> outputs immediately at reset values, in_ready 1. Release reset, then issue A=0x1, B=0x1 -> result 0x2 with normal latency.
- WORDS=1 build: A=0xFFFF, B=0x0001 -> result 0x0000, cout 1, out_valid after 1 RUN cycle. A=0x8000 - 0x0001 -> result 0x7FFF, overflow 1.

Source files
------------

// File: rtl/mw_add_seq_if.sv
// Bundles the request/response handshake and the 16-bit adder bus of mw_add_seq.
// slave = the sequencer, master = whoever supplies operands and the adder.
interface mw_add_seq_if #(
  parameter int W     = 16,
  parameter int WORDS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [W*WORDS-1:0]   op_a;
  logic [W*WORDS-1:0]   op_b;
  logic                 op_cin;
  logic                 op_sub;
  logic [W-1:0]         add_a;
  logic [W-1:0]         add_b;
  logic                 add_cin;
  logic [W-1:0]         add_sum;
  logic                 add_cout;
  logic                 out_valid;
  logic                 out_ready;
  logic [W*WORDS-1:0]   result;
  logic                 cout;
  logic                 overflow;

  modport slave (
    input  in_valid, op_a, op_b, op_cin, op_sub, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, result, cout, overflow
  );

  modport master (
    output in_valid, op_a, op_b, op_cin, op_sub, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, result, cout, overflow
  );
endinterface

// File: rtl/mw_add_seq.sv
// Multi-precision add/subtract sequencer: walks WORDS slices of W bits through an
// external combinational adder, LS word first, chaining the carry through a flop.
module mw_add_seq_word #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] sum,
  output logic [W-1:0] word
);
  logic [W-1:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (en) word_d = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) word_q <= '0;
    else     word_q <= word_d;
  end

  assign word = word_q;
endmodule

module mw_add_seq #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input logic         clk,
  input logic         rst,
  mw_add_seq_if.slave bus
);
  localparam int              IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic                    sub_q, sub_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;
  logic [WORDS-1:0][W-1:0] a_q, a_d, b_q, b_d;
  logic [WORDS-1:0][W-1:0] res_w;
  logic [W-1:0]            a_word, b_word, add_a, add_b;
  logic                    add_cin, wr_en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    a_word  = '0;
    b_word  = '0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    wr_en   = 1'b0;

    for (int i = 0; i < WORDS; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_word = a_q[i];
        b_word = b_q[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          sub_d   = bus.op_sub;
          // subtract is A + ~B + 1, so the +1 rides in on the first carry
          carry_d = bus.op_sub ? 1'b1 : bus.op_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_word;
        add_b   = b_word ^ {W{sub_q}};
        add_cin = carry_q;
        wr_en   = 1'b1;
        carry_d = bus.add_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST) begin
          cout_d  = bus.add_cout;
          ovf_d   = (add_a[W-1] == add_b[W-1]) & (bus.add_sum[W-1] != add_a[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  for (genvar i = 0; i < WORDS; i++) begin : g_word
    mw_add_seq_word #(.W(W)) u_word (
      .clk  (clk),
      .rst  (rst),
      .en   (wr_en && (idx_q == IDXW'(i))),
      .sum  (bus.add_sum),
      .word (res_w[i])
    );
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.add_a     = add_a;
  assign bus.add_b     = add_b;
  assign bus.add_cin   = add_cin;
  assign bus.result    = res_w;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mw_add_seq.sv
// Bench for mw_add_seq: a WORDS=4 and a WORDS=1 instance, each wired to a behavioural
// 16-bit adder, checked against whole-width arithmetic.
module tb_mw_add_seq;
  localparam int W     = 16;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic cins[$];

  mw_add_seq_if #(.W(W), .WORDS(WORDS)) bus4 ();
  mw_add_seq_if #(.W(W), .WORDS(1))     bus1 ();

  mw_add_seq #(.W(W), .WORDS(WORDS)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  mw_add_seq #(.W(W), .WORDS(1))     dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  assign {bus4.add_cout, bus4.add_sum} = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + {16'b0, bus4.add_cin};
  assign {bus1.add_cout, bus1.add_sum} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {16'b0, bus1.add_cin};

  // Returns {overflow, cout, result} of a single nb-bit wide add or subtract.
  function automatic logic [65:0] model(input int nb, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask, r;
    logic [64:0] s;
    logic        sa, sb, sr, c, v;
    mask = (nb == 64) ? '1 : ((64'(1) << nb) - 64'(1));
    s    = {1'b0, a} + {1'b0, b} + 65'(cin);
    r    = (sub ? (a - b) : s[63:0]) & mask;
    sa   = a[nb-1];
    sb   = b[nb-1];
    sr   = r[nb-1];
    c    = sub ? (a >= b) : s[nb];
    v    = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {v, c, r};
  endfunction

  task automatic do_op4(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input logic sub,
                        output int lat, output logic [N-1:0] res, output logic c, output logic v);
    int guard;
    guard = 0;
    cins.delete();
    while (!bus4.in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    bus4.in_valid = 1'b1;
    bus4.op_a = a; bus4.op_b = b; bus4.op_cin = cin; bus4.op_sub = sub;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.op_a   = {$urandom, $urandom};
    bus4.op_b   = {$urandom, $urandom};
    bus4.op_cin = 1'($urandom_range(1));
    bus4.op_sub = 1'($urandom_range(1));
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      cins.push_back(bus4.add_cin);
      @(posedge clk); #1; lat++;
    end
    res = bus4.result; c = bus4.cout; v = bus4.overflow;
  endtask

  task automatic finish4();
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  task automatic do_op1(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                        output int lat, output logic [W-1:0] res, output logic c, output logic v);
    int guard;
    guard = 0;
    while (!bus1.in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    bus1.in_valid = 1'b1;
    bus1.op_a = a; bus1.op_b = b; bus1.op_cin = cin; bus1.op_sub = sub;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.op_a = 16'($urandom); bus1.op_b = 16'($urandom);
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = bus1.result; c = bus1.cout; v = bus1.overflow;
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
  endtask

  // Directed plus model check of one WORDS=4 operation; name tags the FAIL lines.
  task automatic check4(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub);
    int lat; logic [N-1:0] res; logic c, v; logic [65:0] m;
    m = model(N, a, b, cin, sub);
    do_op4(a, b, cin, sub, lat, res, c, v);
    checks++; if (lat !== WORDS) begin failures++; $display("FAIL %s latency got %0d want %0d", name, lat, WORDS); end
    checks++; if (res !== m[63:0]) begin failures++; $display("FAIL %s result got %h want %h", name, res, m[63:0]); end
    checks++; if (c !== m[64]) begin failures++; $display("FAIL %s cout got %b want %b", name, c, m[64]); end
    checks++; if (v !== m[65]) begin failures++; $display("FAIL %s overflow got %b want %b", name, v, m[65]); end
    finish4();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_hs got rdy=%b vld=%b want 1 0", bus4.in_ready, bus4.out_valid); end
    checks++; if ({bus4.result, bus4.cout, bus4.overflow} !== '0) begin failures++;
      $display("FAIL reset_out got %h %b %b want 0", bus4.result, bus4.cout, bus4.overflow); end
    checks++; if ({bus4.add_a, bus4.add_b, bus4.add_cin} !== '0) begin failures++;
      $display("FAIL reset_adder got %h %h %b want 0", bus4.add_a, bus4.add_b, bus4.add_cin); end
    checks++; if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.result !== '0) begin failures++;
      $display("FAIL reset_w1 got rdy=%b vld=%b res=%h", bus1.in_ready, bus1.out_valid, bus1.result); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus4.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_rdy got %b want 1", bus4.in_ready); end
  endtask

  task automatic test_carry_chain();
    int lat; logic [N-1:0] res; logic c, v; logic [3:0] seq;
    do_op4('1, 64'h1, 1'b0, 1'b0, lat, res, c, v);
    checks++; if (lat !== 4) begin failures++; $display("FAIL chain latency got %0d want 4", lat); end
    checks++; if (res !== 64'h0 || c !== 1'b1 || v !== 1'b0) begin failures++;
      $display("FAIL chain result got %h c=%b v=%b want 0 c=1 v=0", res, c, v); end
    seq = 4'hx;
    if (cins.size() == 4) seq = {cins[3], cins[2], cins[1], cins[0]};
    checks++; if (seq !== 4'b1110) begin failures++; $display("FAIL chain add_cin seq got %b want 1110", seq); end
    finish4();
    checks++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin failures++;
      $display("FAIL chain release got vld=%b rdy=%b want 0 1", bus4.out_valid, bus4.in_ready); end
  endtask

  task automatic test_subtract();
    int lat; logic [N-1:0] res; logic c, v;
    do_op4(64'h0, 64'h1, 1'b1, 1'b1, lat, res, c, v);
    checks++; if (res !== '1 || c !== 1'b0 || v !== 1'b0) begin failures++;
      $display("FAIL sub_borrow got %h c=%b v=%b want ffffffffffffffff c=0 v=0", res, c, v); end
    finish4();
    do_op4(64'h5, 64'h3, 1'b0, 1'b1, lat, res, c, v);
    checks++; if (res !== 64'h2 || c !== 1'b1) begin failures++;
      $display("FAIL sub_small got %h c=%b want 2 c=1", res, c); end
    finish4();
  endtask

  task automatic test_overflow();
    int lat; logic [N-1:0] res; logic c, v;
    do_op4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, res, c, v);
    checks++; if (res !== 64'h8000_0000_0000_0000 || v !== 1'b1 || c !== 1'b0) begin failures++;
      $display("FAIL ovf_add got %h c=%b v=%b want 8000000000000000 c=0 v=1", res, c, v); end
    finish4();
    do_op4(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, lat, res, c, v);
    checks++; if (res !== 64'h7FFF_FFFF_FFFF_FFFF || v !== 1'b1 || c !== 1'b1) begin failures++;
      $display("FAIL ovf_sub got %h c=%b v=%b want 7fffffffffffffff c=1 v=1", res, c, v); end
    finish4();
  endtask

  task automatic test_backpressure();
    int lat; logic [N-1:0] res; logic c, v; logic [65:0] m;
    m = model(N, 64'hDEAD_BEEF_0123_4567, 64'hFEED_0000_9999_0001, 1'b0, 1'b1);
    do_op4(64'hDEAD_BEEF_0123_4567, 64'hFEED_0000_9999_0001, 1'b0, 1'b1, lat, res, c, v);
    for (int i = 0; i < 3; i++) begin
      bus4.in_valid = 1'b1;
      bus4.op_a = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++; if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) begin failures++;
        $display("FAIL bp_hs cycle %0d got vld=%b rdy=%b want 1 0", i, bus4.out_valid, bus4.in_ready); end
      checks++; if ({bus4.overflow, bus4.cout, bus4.result} !== m[65:0]) begin failures++;
        $display("FAIL bp_hold cycle %0d got %b %b %h want %h", i, bus4.overflow, bus4.cout, bus4.result, m); end
    end
    bus4.in_valid = 1'b0;
    finish4();
    checks++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin failures++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1", bus4.out_valid, bus4.in_ready); end
    checks++; if (bus4.result !== m[63:0]) begin failures++;
      $display("FAIL bp_idle_hold got %h want %h", bus4.result, m[63:0]); end
    do_op4(64'h1234, 64'h1, 1'b0, 1'b0, lat, res, c, v);
    checks++; if (res !== 64'h1235 || lat !== 4) begin failures++;
      $display("FAIL b2b got %h lat=%0d want 1235 lat=4", res, lat); end
    finish4();
  endtask

  task automatic test_reset_mid();
    int lat; logic [N-1:0] res; logic c, v;
    bus4.in_valid = 1'b1;
    bus4.op_a = 64'h0101_0202_0303_0404; bus4.op_b = 64'h1111_1111_1111_1111;
    bus4.op_cin = 1'b1; bus4.op_sub = 1'b0;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus4.result[31:0] !== 32'h1414_1516) begin failures++;
      $display("FAIL mid_partial got %h want 14141516", bus4.result[31:0]); end
    rst = 1'b1;
    #1;
    checks++; if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.result !== '0) begin failures++;
      $display("FAIL mid_reset got rdy=%b vld=%b res=%h want 1 0 0", bus4.in_ready, bus4.out_valid, bus4.result); end
    checks++; if ({bus4.add_a, bus4.add_b, bus4.add_cin, bus4.cout, bus4.overflow} !== '0) begin failures++;
      $display("FAIL mid_reset_adder got %h %h %b", bus4.add_a, bus4.add_b, bus4.add_cin); end
    @(negedge clk) rst = 1'b0;
    do_op4(64'h1, 64'h1, 1'b0, 1'b0, lat, res, c, v);
    checks++; if (res !== 64'h2 || lat !== 4) begin failures++;
      $display("FAIL mid_recover got %h lat=%0d want 2 lat=4", res, lat); end
    finish4();
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(3))
        0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        1: begin a = '1; b = 64'($urandom_range(3)); end
        2: begin a = 64'h8000_0000_0000_0000 - 64'($urandom_range(2)); b = 64'h7FFF_FFFF_FFFF_FFFF; end
        default: begin a = 64'($urandom_range(15)); b = 64'($urandom_range(15)); end
      endcase
      check4("random", a, b, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
  endtask

  task automatic test_words1();
    int lat; logic [W-1:0] res, a, b; logic c, v, cin, sub; logic [65:0] m;
    do_op1(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, res, c, v);
    checks++; if (res !== 16'h0 || c !== 1'b1 || lat !== 1) begin failures++;
      $display("FAIL w1_carry got %h c=%b lat=%0d want 0 c=1 lat=1", res, c, lat); end
    do_op1(16'h8000, 16'h0001, 1'b0, 1'b1, lat, res, c, v);
    checks++; if (res !== 16'h7FFF || v !== 1'b1) begin failures++;
      $display("FAIL w1_ovf got %h v=%b want 7fff v=1", res, v); end
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
      m = model(W, 64'(a), 64'(b), cin, sub);
      do_op1(a, b, cin, sub, lat, res, c, v);
      checks++; if ({v, c, res} !== {m[65], m[64], m[15:0]} || lat !== 1) begin failures++;
        $display("FAIL w1_random got v=%b c=%b %h lat=%0d want v=%b c=%b %h", v, c, res, lat, m[65], m[64], m[15:0]); end
    end
  endtask

  initial begin
    bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.op_cin = 1'b0; bus4.op_sub = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.op_cin = 1'b0; bus1.op_sub = 1'b0;
    bus1.out_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_words1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
